// File: rtl/ok_eh_pkg.sv
// rtl/ok_eh_pkg.sv - shared types and helpers for the okEH return-lane arbiter
// Purpose: okEH lane width, arbiter state encoding, owner-index width helper.
// Ports: none (package).
package ok_eh_pkg;

  localparam int OK_EH_W = 65;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Owner index width; a single source still gets a 1-bit index.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin requester select
// Purpose: find the first set bit of req_i at or after ptr_i, wrapping modulo N.
// Ports:
//   req_i   in  N   request vector
//   ptr_i   in  OW  round-robin start position
//   found_o out 1   at least one request is set
//   idx_o   out OW  index of the selected requester (0 when none)
module rr_pick
  import ok_eh_pkg::*;
#(
  parameter int  N  = 4,
  localparam int OW = owner_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [OW-1:0] ptr_i,
  output logic          found_o,
  output logic [OW-1:0] idx_o
);

  always_comb begin
    int           pos;
    logic [N-1:0] rot;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    rot     = '0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr_i) + i) % N;
      // Shift instead of a variable bit-select so N=1 needs no index bits.
      rot = req_i >> pos;
      if (!found_o && rot[0]) begin
        found_o = 1'b1;
        idx_o   = OW'(pos);
      end
    end
  end

endmodule

// File: rtl/ok_eh_arbiter.sv
// rtl/ok_eh_arbiter.sv - round-robin arbiter sharing one okEH return lane
// Purpose: grant one source at a time, lock until its last beat, forward its
//   beats with one cycle of latency, drive zero otherwise, watchdog stalled owners.
// Ports:
//   okClk   in  1       clock, rising edge
//   reset_n in  1       asynchronous active-low reset
//   req     in  N       source k has a valid beat
//   last    in  N       source k's beat ends its transaction
//   data    in  N*65    source k's beat at data[k*65 +: 65]
//   gnt     out N       one-hot registered grant
//   okEH    out 65      registered forwarded beat, zero when idle
//   busy    out 1       arbiter is in BUSY
//   owner   out OW      current/last owner index
//   err_to  out 1       sticky watchdog error
//   err_clr in  1       clears err_to (a same-cycle set wins)
module ok_eh_arbiter
  import ok_eh_pkg::*;
#(
  parameter int  N       = 4,
  parameter int  TIMEOUT = 255,
  localparam int OW      = owner_w(N)
) (
  input  logic                 okClk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         last,
  input  logic [N*OK_EH_W-1:0] data,
  output logic [N-1:0]         gnt,
  output logic [OK_EH_W-1:0]   okEH,
  output logic                 busy,
  output logic [OW-1:0]        owner,
  output logic                 err_to,
  input  logic                 err_clr
);

  arb_state_e         state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [OK_EH_W-1:0] okeh_q, okeh_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [15:0]        wd_q, wd_d;
  logic               err_q, err_d;

  logic               pick_found;
  logic [OW-1:0]      pick_idx;
  logic [OK_EH_W-1:0] fwd_data;
  logic               beat;
  logic               beat_last;
  logic [16:0]        wd_inc;
  logic               wd_hit;
  logic [OW-1:0]      ptr_adv;
  logic               err_set;

  rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Grant is one-hot, so this select can only ever yield one source's data.
  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) fwd_data = data[k*OK_EH_W +: OK_EH_W];
    end
  end

  assign beat      = |(gnt_q & req);
  assign beat_last = |(gnt_q & req & last);
  assign wd_inc    = {1'b0, wd_q} + 17'd1;
  assign wd_hit    = (wd_inc == 17'(TIMEOUT));
  assign ptr_adv   = (int'(owner_q) == N - 1) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    okeh_d  = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = N'(1) << pick_idx;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        if (beat) begin
          okeh_d = fwd_data;
          wd_d   = '0;
          if (beat_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_adv;
          end
        end else begin
          wd_d = wd_inc[15:0];
          // Stalled owner: release as if it had sent last, and flag it.
          if (wd_hit) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_adv;
            wd_d    = '0;
            err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      okeh_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      okeh_q  <= okeh_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign okEH   = okeh_q;
  assign busy   = (state_q == BUSY);
  assign owner  = owner_q;
  assign err_to = err_q;

endmodule

// File: tb/tb_ok_eh_arbiter.sv
// tb/tb_ok_eh_arbiter.sv - self-checking bench for ok_eh_arbiter (N=4 and N=1)
module tb_ok_eh_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0, last = '0, gnt;
  logic [259:0] data = '0;
  logic [64:0]  okeh;
  logic         busy, err_to, err_clr = 1'b0;
  logic [1:0]   owner;

  logic [0:0]   req1 = '0, last1 = '0, gnt1;
  logic [64:0]  data1 = '0, okeh1;
  logic         busy1, err1;
  logic [0:0]   owner1;

  int vectors = 0;
  int errors  = 0;
  logic [64:0] exp_q[$];
  logic [64:0] ev;

  localparam logic [64:0] ALL1 = 65'h1_FFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  ok_eh_arbiter #(.N(4), .TIMEOUT(255)) dut (
    .okClk(clk), .reset_n(rst_n), .req(req), .last(last), .data(data),
    .gnt(gnt), .okEH(okeh), .busy(busy), .owner(owner), .err_to(err_to),
    .err_clr(err_clr)
  );

  ok_eh_arbiter #(.N(1), .TIMEOUT(255)) dut1 (
    .okClk(clk), .reset_n(rst_n), .req(req1), .last(last1), .data(data1),
    .gnt(gnt1), .okEH(okeh1), .busy(busy1), .owner(owner1), .err_to(err1),
    .err_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] sb_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic [64:0] rnd65();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[64:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    vectors++; if (okeh !== 65'h0) begin errors++; $display("FAIL reset_okeh got %h want 0", okeh); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    vectors++; if (err_to !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_to); end
    vectors++; if (gnt1 !== 1'b0 || okeh1 !== 65'h0) begin errors++; $display("FAIL reset_n1 got gnt %b okeh %h want 0", gnt1, okeh1); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [64:0] beats [3];
    req = 4'b0100;
    last = 4'b0000;
    beats[0] = rnd65(); beats[1] = rnd65(); beats[2] = rnd65();
    data[2*65 +: 65] = beats[0];
    tick();
    vectors++; if (gnt !== 4'b0100) begin errors++; $display("FAIL burst_grant got %b want 0100", gnt); end
    vectors++; if (okeh !== 65'h0) begin errors++; $display("FAIL burst_pre_okeh got %h want 0", okeh); end
    for (int b = 0; b < 3; b++) begin
      data[2*65 +: 65] = beats[b];
      last[2] = (b == 2);
      exp_q.push_back(beats[b]);
      tick();
      ev = sb_pop();
      vectors++; if (okeh !== ev) begin errors++; $display("FAIL burst_beat%0d got %h want %h", b, okeh, ev); end
      vectors++; if (gnt !== ((b < 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL burst_gnt%0d got %b", b, gnt); end
    end
    req = '0;
    last = '0;
    tick();
    vectors++; if (okeh !== 65'h0 || busy !== 1'b0) begin errors++; $display("FAIL burst_after got okeh %h busy %b want 0 0", okeh, busy); end
  endtask

  task automatic test_rr_order();
    int order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) data[k*65 +: 65] = {1'b1, 32'hC0DE_0000 + k, 32'h5A5A_0000 + k};
    req = 4'b1111;
    last = 4'b1111;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (gnt !== (4'b0001 << order[i]) || owner !== 2'(order[i])) begin errors++; $display("FAIL rr_grant%0d got gnt %b owner %0d want src %0d", i, gnt, owner, order[i]); end
      vectors++; if (okeh !== 65'h0) begin errors++; $display("FAIL rr_grant_okeh%0d got %h want 0", i, okeh); end
      exp_q.push_back(data[order[i]*65 +: 65]);
      tick();
      ev = sb_pop();
      vectors++; if (okeh !== ev) begin errors++; $display("FAIL rr_beat%0d got %h want %h", i, okeh, ev); end
      vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_turnaround%0d got %b want 0000", i, gnt); end
    end
    req = '0;
    last = '0;
  endtask

  task automatic test_timeout();
    logic [64:0] d1, d2;
    d1 = rnd65();
    d2 = rnd65();
    data[1*65 +: 65] = d1;
    data[2*65 +: 65] = d2;
    req = 4'b0010;
    tick();
    vectors++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", gnt); end
    exp_q.push_back(d1);
    tick();
    ev = sb_pop();
    vectors++; if (okeh !== ev) begin errors++; $display("FAIL to_beat got %h want %h", okeh, ev); end
    req = 4'b0100;
    for (int t = 1; t <= 255; t++) begin
      tick();
      vectors++; if (gnt !== ((t < 255) ? 4'b0010 : 4'b0000) || err_to !== (t == 255) || okeh !== 65'h0) begin errors++; $display("FAIL to_wait%0d got gnt %b err %b okeh %h", t, gnt, err_to, okeh); end
    end
    tick();
    vectors++; if (gnt !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL to_next got gnt %b owner %0d want 0100 2", gnt, owner); end
    vectors++; if (err_to !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err_to); end
    last = 4'b0100;
    err_clr = 1'b1;
    exp_q.push_back(d2);
    tick();
    err_clr = 1'b0;
    req = '0;
    last = '0;
    ev = sb_pop();
    vectors++; if (err_to !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", err_to); end
    vectors++; if (okeh !== ev || gnt !== 4'b0000) begin errors++; $display("FAIL to_src2 got okeh %h gnt %b want %h 0000", okeh, gnt, ev); end
  endtask

  task automatic test_isolation();
    logic [64:0] beats [4];
    for (int b = 0; b < 4; b++) beats[b] = rnd65() & ~ALL1 | {1'b0, 64'h0123_4567_89AB_CDE0} ^ 65'(b);
    rst_n = 1'b0;
    tick();
    req = 4'b1001;
    last = 4'b0000;
    data[3*65 +: 65] = ALL1;
    data[0*65 +: 65] = beats[0];
    rst_n = 1'b1;
    tick();
    vectors++; if (gnt !== 4'b0001) begin errors++; $display("FAIL iso_grant got %b want 0001", gnt); end
    for (int b = 0; b < 4; b++) begin
      data[0*65 +: 65] = beats[b];
      last[0] = (b == 3);
      exp_q.push_back(beats[b]);
      tick();
      ev = sb_pop();
      vectors++; if (okeh !== ev || okeh === ALL1) begin errors++; $display("FAIL iso_beat%0d got %h want %h", b, okeh, ev); end
      vectors++; if (gnt !== ((b < 3) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL iso_gnt%0d got %b", b, gnt); end
    end
    req = 4'b1000;
    last = 4'b1000;
    tick();
    vectors++; if (gnt !== 4'b1000 || okeh !== 65'h0) begin errors++; $display("FAIL iso_src3_grant got gnt %b okeh %h want 1000 0", gnt, okeh); end
    exp_q.push_back(ALL1);
    tick();
    ev = sb_pop();
    vectors++; if (okeh !== ev) begin errors++; $display("FAIL iso_src3_beat got %h want %h", okeh, ev); end
    req = '0;
    last = '0;
  endtask

  task automatic test_reset_mid();
    logic [64:0] e1, e3;
    e1 = rnd65() | 65'h1;
    e3 = rnd65() | 65'h1;
    data[1*65 +: 65] = e1;
    data[3*65 +: 65] = e3;
    req = 4'b1010;
    last = 4'b0010;
    tick();
    vectors++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_grant1 got %b want 0010", gnt); end
    exp_q.push_back(e1);
    tick();
    ev = sb_pop();
    vectors++; if (okeh !== ev) begin errors++; $display("FAIL rm_beat1 got %h want %h", okeh, ev); end
    tick();
    vectors++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rm_grant3 got %b want 1000", gnt); end
    exp_q.push_back(e3);
    tick();
    ev = sb_pop();
    vectors++; if (okeh !== ev || gnt !== 4'b1000) begin errors++; $display("FAIL rm_beat3 got okeh %h gnt %b", okeh, gnt); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (gnt !== 4'b0 || okeh !== 65'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got gnt %b okeh %h busy %b want 0", gnt, okeh, busy); end
    tick();
    vectors++; if (gnt !== 4'b0 || okeh !== 65'h0) begin errors++; $display("FAIL rm_held got gnt %b okeh %h want 0", gnt, okeh); end
    rst_n = 1'b1;
    tick();
    vectors++; if (gnt !== 4'b0010 || owner !== 2'd1) begin errors++; $display("FAIL rm_regrant got gnt %b owner %0d want 0010 1", gnt, owner); end
    exp_q.push_back(e1);
    tick();
    req = '0;
    last = '0;
    ev = sb_pop();
    vectors++; if (okeh !== ev || gnt !== 4'b0) begin errors++; $display("FAIL rm_finish got okeh %h gnt %b", okeh, gnt); end
  endtask

  task automatic test_n1_back_to_back();
    logic g;
    logic [64:0] d;
    g = 1'b0;
    req1 = 1'b1;
    last1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = rnd65();
      data1 = d;
      exp_q.push_back(g ? d : 65'h0);
      tick();
      g = ~g;
      ev = sb_pop();
      vectors++; if (gnt1 !== g || busy1 !== g || owner1 !== 1'b0) begin errors++; $display("FAIL n1_gnt%0d got gnt %b busy %b want %b", i, gnt1, busy1, g); end
      vectors++; if (okeh1 !== ev) begin errors++; $display("FAIL n1_okeh%0d got %h want %h", i, okeh1, ev); end
    end
    req1 = 1'b0;
    last1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rr_order();
    test_timeout();
    test_isolation();
    test_reset_mid();
    test_n1_back_to_back();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
